// File: rtl/button_events_pkg.sv
// Shared types and constants for the front-panel button event generator.
package button_events_pkg;

  localparam int unsigned EVT_W = 2;

  typedef enum logic [EVT_W-1:0] {
    PRESS   = 2'd0,
    RELEASE = 2'd1,
    HOLD    = 2'd2,
    REPEAT  = 2'd3
  } evt_code_t;

  typedef enum logic [1:0] {
    UP   = 2'd0,
    DOWN = 2'd1,
    HELD = 2'd2
  } btn_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_events_if.sv
// Event handshake towards the parameter-edit controller.
interface button_events_if
  import button_events_pkg::*;
#(
  parameter int unsigned BW = 2
) ();

  logic             evt_valid;
  logic             evt_ready;
  logic [EVT_W-1:0] evt_code;
  logic [BW-1:0]    evt_btn;
  logic             evt_lost;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_btn,
    output evt_lost,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_btn,
    input  evt_lost,
    output evt_ready
  );

endinterface

// File: rtl/button_events_fifo.sv
// Small synchronous FIFO for queued button events; head is presented combinationally.
module event_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0]               wr_ptr_q;
  logic [AW-1:0]               rd_ptr_q;
  logic [CW-1:0]               count_q;
  logic                        do_push;
  logic                        do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/button_events.sv
// Turns debounced button levels into PRESS/RELEASE/HOLD/REPEAT events,
// buffered per button in a one-entry slot and then queued in a FIFO.
module button_events
  import button_events_pkg::*;
#(
  parameter int unsigned N_BTN      = 4,
  parameter int unsigned HOLD_CYC   = 25_000_000,
  parameter int unsigned REPEAT_CYC = 5_000_000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn,
  button_events_if.master  evt
);

  localparam int unsigned BW          = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam int unsigned TW_RAW      = $clog2(max_u(HOLD_CYC, REPEAT_CYC));
  localparam int unsigned TW          = (TW_RAW > 0) ? TW_RAW : 1;
  localparam int unsigned FW          = EVT_W + BW;
  localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_CYC - 1);

  logic [N_BTN-1:0]             btn_q;
  logic [N_BTN-1:0]             slot_v;
  logic [N_BTN-1:0][EVT_W-1:0]  slot_code;
  logic [N_BTN-1:0]             drain;
  logic [N_BTN-1:0]             lost;
  logic                         lost_q;

  logic                         arb_found;
  logic [BW-1:0]                arb_sel;
  logic [N_BTN-1:0]             arb_onehot;

  logic                         fifo_push;
  logic                         fifo_pop;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [FW-1:0]                fifo_wdata;
  logic [FW-1:0]                fifo_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q  <= '0;
      lost_q <= 1'b0;
    end else begin
      btn_q  <= btn;
      lost_q <= lost_q | (|lost);
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_state_t    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          emit;
    evt_code_t     emit_code;
    logic          slot_v_q, slot_v_d;
    evt_code_t     slot_code_q, slot_code_d;

    always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      emit        = 1'b0;
      emit_code   = PRESS;
      slot_v_d    = slot_v_q;
      slot_code_d = slot_code_q;

      // Release is checked before expiry so it wins on the expiry cycle.
      unique case (state_q)
        UP: begin
          if (btn[g] && !btn_q[g]) begin
            emit      = 1'b1;
            emit_code = PRESS;
            state_d   = DOWN;
            timer_d   = '0;
          end
        end
        DOWN: begin
          timer_d = timer_q + 1'b1;
          if (!btn[g]) begin
            emit      = 1'b1;
            emit_code = RELEASE;
            state_d   = UP;
          end else if (timer_q == HOLD_LAST) begin
            emit      = 1'b1;
            emit_code = HOLD;
            state_d   = HELD;
            timer_d   = '0;
          end
        end
        HELD: begin
          timer_d = timer_q + 1'b1;
          if (!btn[g]) begin
            emit      = 1'b1;
            emit_code = RELEASE;
            state_d   = UP;
          end else if (timer_q == REPEAT_LAST) begin
            emit      = 1'b1;
            emit_code = REPEAT;
            timer_d   = '0;
          end
        end
        default: state_d = UP;
      endcase

      if (emit) begin
        slot_v_d    = 1'b1;
        slot_code_d = emit_code;
      end else if (drain[g]) begin
        slot_v_d    = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q     <= UP;
        timer_q     <= '0;
        slot_v_q    <= 1'b0;
        slot_code_q <= PRESS;
      end else begin
        state_q     <= state_d;
        timer_q     <= timer_d;
        slot_v_q    <= slot_v_d;
        slot_code_q <= slot_code_d;
      end
    end

    assign slot_v[g]    = slot_v_q;
    assign slot_code[g] = slot_code_q;
    assign lost[g]      = emit & slot_v_q & ~drain[g];
  end

  always_comb begin
    arb_found  = 1'b0;
    arb_sel    = '0;
    arb_onehot = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      if (!arb_found && slot_v[i]) begin
        arb_found     = 1'b1;
        arb_sel       = BW'(i);
        arb_onehot[i] = 1'b1;
      end
    end
  end

  assign fifo_push  = arb_found & ~fifo_full;
  assign drain      = fifo_push ? arb_onehot : '0;
  assign fifo_wdata = {slot_code[arb_sel], arb_sel};
  assign fifo_pop   = ~fifo_empty & evt.evt_ready;

  event_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign evt.evt_valid              = ~fifo_empty;
  assign {evt.evt_code, evt.evt_btn} = fifo_rdata;
  assign evt.evt_lost               = lost_q;

endmodule
